// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Writer-side counterpart to the instruction memory read port. Accepts a
// program image as a byte stream over a valid/ready handshake, packs every
// four bytes MSB-first into a 32-bit word and writes the words to instruction
// memory at consecutive word addresses starting at 0. busy holds the CPU/PC in
// reset while an image is being loaded.
//
// Optional feature (macro INSTRUCTION_LOADER_CHECKSUM_EN):
//   After the last word, four further bytes carry the expected XOR of all
//   written words. error is raised on a mismatch. Without the macro there is
//   no checksum state or logic and error is tied low.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   load request, honoured only in IDLE or DONE
//   length     in   words to load (clamped to 2^ADDR_W), sampled on start
//   byte_data  in   stream byte
//   byte_valid in   byte_data valid
//   byte_ready out  loader accepts a byte this cycle
//   mem_we     out  one-cycle write pulse per word
//   mem_addr   out  word write address
//   mem_wdata  out  instruction word
//   busy       out  load in progress
//   done       out  last load completed (held until next start / reset)
//   error      out  checksum mismatch (constant 0 without the macro)
// -----------------------------------------------------------------------------
module instruction_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE, S_CSUM
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_RECV, S_WRITE, S_DONE
  } state_e;
`endif

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_e            state_q;
  logic [1:0]        bcnt_q;
  logic [23:0]       shift_q;
  logic [LEN_W-1:0]  wcnt_q;
  logic [LEN_W-1:0]  len_q;
  logic              byte_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              busy_q;
  logic              done_q;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [31:0]       csum_q;
  logic              error_q;
`endif

  logic              xfer_d;
  logic [31:0]       word_d;
  logic [LEN_W-1:0]  wcnt_d;
  logic [LEN_W-1:0]  len_d;

  always_comb begin
    xfer_d = byte_valid & byte_ready_q;
    // Completed word if the current byte is the fourth of the group.
    word_d = {shift_q, byte_data};
    wcnt_d = wcnt_q + LEN_W'(1);
    len_d  = (length > MAX_LEN) ? MAX_LEN : length;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      shift_q      <= '0;
      wcnt_q       <= '0;
      len_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      csum_q       <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q  <= len_d;
            wcnt_q <= '0;
            bcnt_q <= '0;
            done_q <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            error_q <= 1'b0;
`endif
            if (len_d == '0) begin
              // Empty image: finish immediately without ever raising busy.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_RECV;
              busy_q       <= 1'b1;
              byte_ready_q <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (xfer_d) begin
            bcnt_q  <= bcnt_q + 2'd1;
            shift_q <= word_d[23:0];
            if (bcnt_q == 2'd3) begin
              mem_wdata_q  <= word_d;
              mem_addr_q   <= wcnt_q[ADDR_W-1:0];
              mem_we_q     <= 1'b1;
              byte_ready_q <= 1'b0;
              state_q      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          wcnt_q <= wcnt_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ mem_wdata_q;
`endif
          byte_ready_q <= 1'b1;
          if (wcnt_d == len_q) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            state_q <= S_CSUM;
`else
            state_q      <= S_DONE;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
`endif
          end else begin
            state_q <= S_RECV;
          end
        end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        S_CSUM: begin
          // csum_q already includes the final word (folded in during WRITE).
          if (xfer_d) begin
            bcnt_q  <= bcnt_q + 2'd1;
            shift_q <= word_d[23:0];
            if (bcnt_q == 2'd3) begin
              error_q      <= (word_d != csum_q);
              byte_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= S_DONE;
            end
          end
        end
`endif

        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer-side counterpart to the instruction memory read port.
- Receives a program image as a byte stream over a valid/ready handshake.
- Assembles each group of 4 bytes into a 32-bit instruction word and drives a synchronous write port into instruction memory, at word addresses 0, 1, 2, ...
- Asserts busy while loading; the top level uses busy to hold the CPU and PC in reset until the image is in memory.

Parameters:
- ADDR_W, 10, word address width; memory depth is 2^ADDR_W words (1024).
- LEN_W, 11, width of the length input; must be ADDR_W+1 so a full-memory load (1024) can be expressed.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle load request; sampled only in IDLE or DONE.
- length  input  LEN_W  number of words to load; sampled on the accepted start.
- byte_data  input  8  stream byte.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_W  word write address.
- mem_wdata  output  32  instruction word.
- busy  output  1  load in progress (CPU hold).
- done  output  1  last load completed; held until next accepted start or reset.
- error  output  1  checksum mismatch (see Optional Feature); otherwise constant 0.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - State goes to IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0.
  - Byte counter and word counter cleared.
- Reset asserted mid-load:
  - Any partially assembled word is discarded; no write is issued.
  - Words already written remain in memory.
- States: IDLE, RECV, WRITE, DONE.
- IDLE / DONE:
  - start=1 latches len_eff = min(length, 2^ADDR_W), clears the word counter and done.
  - If len_eff==0: go to DONE next cycle (done=1, busy never asserts, no writes).
  - Else: go to RECV with busy=1.
  - start in any other state is ignored.
- RECV:
  - byte_ready=1.
  - A transfer occurs when byte_valid && byte_ready.
  - Bytes are assembled MSB-first: the 1st byte goes to bits [31:24], the 4th to [7:0].
  - A 2-bit byte counter advances on each transfer.
  - On the 4th transfer: the full word is registered into mem_wdata, mem_addr = word counter, and the next state is WRITE.
  - byte_valid=0 simply stalls; there is no timeout.
- WRITE (exactly one cycle):
  - mem_we=1 and byte_ready=0.
  - Next cycle: the word counter increments.
  - If the incremented count == len_eff: go to DONE (busy=0, done=1). Otherwise return to RECV.
  - Throughput: one word per 5 cycles when byte_valid is held high.
- mem_we is never high outside WRITE.
- mem_addr and mem_wdata hold their last values between writes.
- Word address never exceeds 2^ADDR_W−1; there is no wrap-around because len_eff is clamped.
- Extra bytes presented after completion are not accepted (byte_ready=0).
- busy=1 exactly from the cycle after an accepted start with len_eff>0 until the cycle DONE is entered.

Optional Feature:
- Macro: INSTRUCTION_LOADER_CHECKSUM_EN.
- When defined:
  - A running 32-bit XOR of all written words is kept, cleared on accepted start.
  - After the last WRITE, state CSUM is entered (byte_ready=1, busy=1) and accepts 4 further bytes, assembled MSB-first as the expected checksum.
  - Then go to DONE with error = (expected != running XOR). error holds until the next accepted start or reset.
  - len_eff==0 still goes directly to DONE with no checksum bytes and error=0.
- When undefined: no CSUM state, no checksum logic, error tied to 0.

Test Plan:
- Basic load: start with length=2, stream 8'hDE,AD,BE,EF,01,23,45,67 with valid always high -> mem_we pulses twice, 5 cycles apart; (addr 0, 32'hDEADBEEF) then (addr 1, 32'h01234567); done=1, busy=0 afterward.
- Back-pressure: length=1, bytes 8'h11,22,33,44 with byte_valid toggling every other cycle -> single write of 32'h11223344 at addr 0; no extra mem_we; byte_ready=0 during the WRITE cycle.
- Boundaries:
  - length=0 -> done=1 next cycle, busy never high, no writes.
  - length=2047 -> clamped to 1024 words; last write at addr 1023; then DONE; byte_ready=0 thereafter.
- Reset mid-word: length=2, send 6 bytes, assert reset for one cycle -> exactly one write (addr 0); all outputs at reset values; a new start with length=1 writes at addr 0.
- Start while busy: pulse start with length=5 during RECV of a length=1 load -> ignored; load completes after 1 word; done=1.
- Checksum (macro defined): length=2 with words 32'hDEADBEEF, 32'h01234567, then checksum bytes for 32'hDF8EFB88 -> error=0. Repeat with checksum 32'h00000000 -> error=1.
